// File: rtl/nbcac_12di_encoder_seq.sv
// Iterative 12-bit binary to 17-bit NBCAC codeword encoder (greedy subtraction
// over a fixed weight table), with valid/ready handshakes on input and output.
module nbcac_12di_encoder_seq #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] v_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] d_out,
    output logic        busy
);

    if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 &&
        STEPS_PER_CYCLE != 4 && STEPS_PER_CYCLE != 8) begin : g_bad_steps
        $error("STEPS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    localparam logic [4:0] FIRST_K      = 5'd2;
    localparam logic [4:0] STEP_INC     = 5'(STEPS_PER_CYCLE);
    localparam logic [4:0] LAST_BATCH_K = 5'(18 - STEPS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [11:0] rem, rem_nx;
    logic [4:0]  k_idx, k_idx_nx;
    logic [16:0] d_reg, d_nx;
    logic [4:0]  k_cur;
    logic [11:0] w_cur;
    logic        accept;

    // Out-of-range indices return a weight above any even remainder so no bit is set.
    function automatic logic [11:0] weight(input logic [4:0] k);
        case (k)
            5'd2:    weight = 12'd1974;
            5'd3:    weight = 12'd1220;
            5'd4:    weight = 12'd754;
            5'd5:    weight = 12'd466;
            5'd6:    weight = 12'd288;
            5'd7:    weight = 12'd178;
            5'd8:    weight = 12'd110;
            5'd9:    weight = 12'd68;
            5'd10:   weight = 12'd42;
            5'd11:   weight = 12'd26;
            5'd12:   weight = 12'd16;
            5'd13:   weight = 12'd10;
            5'd14:   weight = 12'd6;
            5'd15:   weight = 12'd4;
            5'd16:   weight = 12'd2;
            5'd17:   weight = 12'd2;
            default: weight = 12'hFFF;
        endcase
    endfunction

    // Handshake: a word transfers on a rising edge where valid and ready are both
    // high; valid never depends on ready, and in_ready depends only on out_ready.
    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign d_out     = d_reg;

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        k_idx_nx = k_idx;
        d_nx     = d_reg;
        k_cur    = k_idx;
        w_cur    = 12'd0;

        unique case (state)
            IDLE: ;
            RUN: begin
                // STEPS_PER_CYCLE comparator/subtractor stages chained in one cycle.
                for (int j = 0; j < STEPS_PER_CYCLE; j++) begin
                    k_cur = k_idx + 5'(j);
                    w_cur = weight(k_cur);
                    if (rem_nx >= w_cur) begin
                        d_nx[k_cur - 5'd1] = 1'b1;
                        rem_nx             = rem_nx - w_cur;
                    end
                end
                k_idx_nx = k_idx + STEP_INC;
                if (k_idx == LAST_BATCH_K) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready && !in_valid) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Accept is only possible from IDLE or DONE, including the back-to-back case.
        if (accept) begin
            state_nx = RUN;
            d_nx     = {16'd0, v_in[0]};
            rem_nx   = v_in & 12'hFFE;
            k_idx_nx = FIRST_K;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem   <= 12'd0;
            k_idx <= FIRST_K;
            d_reg <= 17'd0;
        end else begin
            state <= state_nx;
            rem   <= rem_nx;
            k_idx <= k_idx_nx;
            d_reg <= d_nx;
        end
    end

`ifndef SYNTHESIS
    a_hold_under_backpressure : assert property (
        @(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(d_out))
    );

    a_remainder_exhausted : assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == RUN && k_idx == LAST_BATCH_K) |-> (rem_nx == 12'd0)
    );
`endif

endmodule

// File: tb/tb_nbcac_12di_encoder_seq.sv
// Bench for nbcac_12di_encoder_seq: directed scenarios on a STEPS_PER_CYCLE=1 unit,
// then randomized sweeps on four instances (1, 2, 4, 8 steps per cycle) against a model.
module tb_nbcac_12di_encoder_seq;

    localparam int NINST     = 4;
    localparam int CYC_LIMIT = 90000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_a  [NINST];
    logic        in_ready_a  [NINST];
    logic [11:0] v_in_a      [NINST];
    logic        out_valid_a [NINST];
    logic        out_ready_a [NINST];
    logic [16:0] d_out_a     [NINST];
    logic        busy_a      [NINST];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int wt [17] = '{1, 1974, 1220, 754, 466, 288, 178, 110, 68, 42, 26, 16, 10, 6, 4, 2, 2};

    typedef struct {
        int inst;
        int v;
        int acc;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        nbcac_12di_encoder_seq #(.STEPS_PER_CYCLE(1 << g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid_a[g]),
            .in_ready (in_ready_a[g]),
            .v_in     (v_in_a[g]),
            .out_valid(out_valid_a[g]),
            .out_ready(out_ready_a[g]),
            .d_out    (d_out_a[g]),
            .busy     (busy_a[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [16:0] ref_encode(input int v);
        logic [16:0] d;
        int r;
        d = '0;
        r = v;
        if (v % 2 == 1) begin
            d[0] = 1'b1;
            r    = r - 1;
        end
        for (int k = 1; k < 17; k++) begin
            if (r >= wt[k]) begin
                d[k] = 1'b1;
                r    = r - wt[k];
            end
        end
        return d;
    endfunction

    function automatic int weighted_sum(input logic [16:0] d);
        int s;
        s = 0;
        for (int k = 0; k < 17; k++) begin
            if (d[k] === 1'b1) s = s + wt[k];
        end
        return s;
    endfunction

    function automatic int find_first(input int g);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].inst == g) return i;
        end
        return -1;
    endfunction

    // ---------------- directed scenarios (instance 0, one step per cycle) ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int g = 0; g < NINST; g++) begin
            in_valid_a[g]  = 1'b0;
            out_ready_a[g] = 1'b0;
            v_in_a[g]      = 12'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < NINST; g++) begin
            checks++;
            if (out_valid_a[g] !== 1'b0) begin
                failures++;
                $display("FAIL reset_out_valid inst=%0d got=%b expected=0", g, out_valid_a[g]);
            end
            checks++;
            if (busy_a[g] !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy inst=%0d got=%b expected=0", g, busy_a[g]);
            end
            checks++;
            if (d_out_a[g] !== 17'd0) begin
                failures++;
                $display("FAIL reset_d_out inst=%0d got=%h expected=00000", g, d_out_a[g]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < NINST; g++) begin
            checks++;
            if (in_ready_a[g] !== 1'b1) begin
                failures++;
                $display("FAIL reset_in_ready inst=%0d got=%b expected=1", g, in_ready_a[g]);
            end
        end
    endtask

    task automatic encode_one(input logic [11:0] v, input logic [16:0] exp_d, input string nm);
        int n;
        out_ready_a[0] = 1'b1;
        in_valid_a[0]  = 1'b1;
        v_in_a[0]      = v;
        #1;
        checks++;
        if (in_ready_a[0] !== 1'b1) begin
            failures++;
            $display("FAIL %s_in_ready got=%b expected=1", nm, in_ready_a[0]);
        end
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        v_in_a[0]     = 12'($urandom);
        n = 0;
        while (out_valid_a[0] !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL %s_latency got=%0d expected=16", nm, n);
        end
        checks++;
        if (d_out_a[0] !== exp_d) begin
            failures++;
            $display("FAIL %s_d_out v=%0d got=%h expected=%h", nm, v, d_out_a[0], exp_d);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid_a[0] !== 1'b0) begin
            failures++;
            $display("FAIL %s_release got=%b expected=0", nm, out_valid_a[0]);
        end
    endtask

    task automatic test_values();
        logic [11:0] v;
        encode_one(12'd4095, 17'h0148F, "v4095");
        encode_one(12'd0,    17'h00000, "v0");
        encode_one(12'd1,    17'h00001, "v1");
        encode_one(12'd2,    17'h08000, "v2");
        encode_one(12'd100,  17'h02500, "v100");
        encode_one(12'd1975, 17'h00003, "v1975");
        for (int i = 0; i < 6; i++) begin
            v = 12'($urandom);
            encode_one(v, ref_encode(int'(v)), "vrand");
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] v1, v2;
        int n;
        v1 = 12'($urandom);
        v2 = 12'($urandom);
        out_ready_a[0] = 1'b0;
        in_valid_a[0]  = 1'b1;
        v_in_a[0]      = v1;
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        n = 0;
        while (out_valid_a[0] !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL bp_latency got=%0d expected=16", n);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid_a[0] !== 1'b1 || d_out_a[0] !== ref_encode(int'(v1))) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got=%b/%h expected=1/%h", i, out_valid_a[0],
                         d_out_a[0], ref_encode(int'(v1)));
            end
            checks++;
            if (in_ready_a[0] !== 1'b0) begin
                failures++;
                $display("FAIL bp_in_ready cycle=%0d got=%b expected=0", i, in_ready_a[0]);
            end
        end
        out_ready_a[0] = 1'b1;
        in_valid_a[0]  = 1'b1;
        v_in_a[0]      = v2;
        #1;
        checks++;
        if (in_ready_a[0] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_in_ready got=%b expected=1", in_ready_a[0]);
        end
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        v_in_a[0]     = 12'($urandom);
        checks++;
        if (busy_a[0] !== 1'b1 || out_valid_a[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_idle got=busy%b/valid%b expected=busy1/valid0", busy_a[0],
                     out_valid_a[0]);
        end
        n = 0;
        while (out_valid_a[0] !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL b2b_latency got=%0d expected=16", n);
        end
        checks++;
        if (d_out_a[0] !== ref_encode(int'(v2))) begin
            failures++;
            $display("FAIL b2b_d_out got=%h expected=%h", d_out_a[0], ref_encode(int'(v2)));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        out_ready_a[0] = 1'b1;
        in_valid_a[0]  = 1'b1;
        v_in_a[0]      = 12'($urandom);
        @(posedge clk);
        #1;
        in_valid_a[0] = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy_a[0] !== 1'b1) begin
            failures++;
            $display("FAIL midrst_busy_before got=%b expected=1", busy_a[0]);
        end
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_a[0] !== 1'b0 || busy_a[0] !== 1'b0 || d_out_a[0] !== 17'd0) begin
            failures++;
            $display("FAIL midrst_outputs got=valid%b/busy%b/%h expected=valid0/busy0/00000",
                     out_valid_a[0], busy_a[0], d_out_a[0]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || out_valid_a[0] !== 1'b0) begin
            failures++;
            $display("FAIL midrst_release got=ready%b/busy%b/valid%b expected=ready1/busy0/valid0",
                     in_ready_a[0], busy_a[0], out_valid_a[0]);
        end
        encode_one(12'd100, 17'h02500, "midrst_v100");
    endtask

    task automatic test_run_ignore();
        logic [11:0] v;
        int n;
        v = 12'($urandom);
        out_ready_a[0] = 1'b0;
        in_valid_a[0]  = 1'b1;
        v_in_a[0]      = v;
        @(posedge clk);
        #1;
        n = 0;
        while (out_valid_a[0] !== 1'b1 && n < 40) begin
            in_valid_a[0] = 1'($urandom_range(0, 1));
            v_in_a[0]     = 12'($urandom);
            #1;
            checks++;
            if (in_ready_a[0] !== 1'b0) begin
                failures++;
                $display("FAIL ignore_in_ready step=%0d got=%b expected=0", n, in_ready_a[0]);
            end
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL ignore_latency got=%0d expected=16", n);
        end
        checks++;
        if (d_out_a[0] !== ref_encode(int'(v))) begin
            failures++;
            $display("FAIL ignore_d_out got=%h expected=%h", d_out_a[0], ref_encode(int'(v)));
        end
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- randomized sweep on all instances ----------------
    task automatic sweep_drive(input int g, input int n);
        logic [11:0] v;
        int guard;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            v = (g == 0) ? 12'($urandom) : 12'(i);
            if (g == 0 && i == 0) v = 12'd0;
            if (g == 0 && i == 1) v = 12'd4095;
            if ($urandom_range(0, 3) == 0) begin
                in_valid_a[g] = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid_a[g] = 1'b1;
            v_in_a[g]     = v;
            guard = 0;
            @(negedge clk);
            while (in_ready_a[g] !== 1'b1 && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 500) begin
                checks++;
                failures++;
                $display("FAIL sweep_accept_timeout inst=%0d got=no_ready expected=ready", g);
                in_valid_a[g] = 1'b0;
                return;
            end
            e.inst = g;
            e.v    = int'(v);
            e.acc  = cyc + 1;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            in_valid_a[g] = 1'b0;
            v_in_a[g]     = 12'($urandom);
        end
    endtask

    task automatic sweep_monitor(input int g, input int n);
        int got;
        bit seen;
        int idx;
        int exp_v;
        int lat;
        got  = 0;
        seen = 1'b0;
        out_ready_a[g] = ($urandom_range(0, 3) != 0);
        while (got < n) begin
            @(negedge clk);
            if (cyc > CYC_LIMIT) begin
                checks++;
                failures++;
                $display("FAIL sweep_timeout inst=%0d got=%0d expected=%0d", g, got, n);
                break;
            end
            if (out_valid_a[g] === 1'b1) begin
                idx = find_first(g);
                if (idx < 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sweep_spurious inst=%0d got=%h expected=no_output", g, d_out_a[g]);
                    break;
                end
                exp_v = exp_q[idx].v;
                if (!seen) begin
                    lat = cyc - exp_q[idx].acc;
                    checks++;
                    if (lat != (16 >> g)) begin
                        failures++;
                        $display("FAIL sweep_latency inst=%0d v=%0d got=%0d expected=%0d", g, exp_v,
                                 lat, 16 >> g);
                    end
                    seen = 1'b1;
                end
                if (out_ready_a[g]) begin
                    checks++;
                    if (d_out_a[g] !== ref_encode(exp_v)) begin
                        failures++;
                        $display("FAIL sweep_d_out inst=%0d v=%0d got=%h expected=%h", g, exp_v,
                                 d_out_a[g], ref_encode(exp_v));
                    end
                    checks++;
                    if (weighted_sum(d_out_a[g]) != exp_v) begin
                        failures++;
                        $display("FAIL sweep_sum inst=%0d got=%0d expected=%0d", g,
                                 weighted_sum(d_out_a[g]), exp_v);
                    end
                    exp_q.delete(idx);
                    got++;
                    seen = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            out_ready_a[g] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic test_sweep();
        exp_q.delete();
        fork
            sweep_drive(0, 1024);
            sweep_monitor(0, 1024);
            sweep_drive(1, 4096);
            sweep_monitor(1, 4096);
            sweep_drive(2, 4096);
            sweep_monitor(2, 4096);
            sweep_drive(3, 4096);
            sweep_monitor(3, 4096);
        join
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sweep_leftover got=%0d expected=0", exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_values();
        test_backpressure();
        test_reset_mid_run();
        test_run_ignore();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "bench did not finish");
    end

endmodule
